// File: rtl/free_list_if.sv
// Rename-stage free-list port bundle: allocation, graduation free and checkpoint signals.
// The rename stage is the master; the free list is the slave.
interface free_list_if #(
  parameter int PW = 6
);
  logic                 ext_stall;
  logic [1:0]           req_valid;
  logic [1:0][PW-1:0]   alloc_phys_rd;
  logic [1:0]           alloc_valid;
  logic                 int_stall;
  logic                 free_valid;
  logic [PW-1:0]        free_phys_reg;
  logic [PW-1:0]        fl_head_ptr;
  logic                 recall_checkpoint;
  logic [PW-1:0]        new_head;
  logic [PW:0]          free_count;
  logic                 overflow_err;

  modport master (
    output ext_stall, req_valid, free_valid, free_phys_reg, recall_checkpoint, new_head,
    input  alloc_phys_rd, alloc_valid, int_stall, fl_head_ptr, free_count, overflow_err
  );

  modport slave (
    input  ext_stall, req_valid, free_valid, free_phys_reg, recall_checkpoint, new_head,
    output alloc_phys_rd, alloc_valid, int_stall, fl_head_ptr, free_count, overflow_err
  );
endinterface

// File: rtl/free_list.sv
// Physical-register free list: circular FIFO granting up to two registers per cycle,
// reclaiming one per cycle from graduation, with head-pointer checkpoint restore.

// Per-slot grant steering: slot 1 takes the second entry only when slot 0 also requests.
module free_list_lane #(
  parameter int PW   = 6,
  parameter int LANE = 0
) (
  input  logic          grant,
  input  logic [1:0]    req_valid,
  input  logic [PW-1:0] head_ent,
  input  logic [PW-1:0] next_ent,
  output logic          valid,
  output logic [PW-1:0] phys_rd
);
  logic use_next;

  always_comb begin
    use_next = (LANE != 0) && req_valid[0];
    valid    = grant && req_valid[LANE];
    phys_rd  = '0;
    if (valid) phys_rd = use_next ? next_ent : head_ent;
  end
endmodule

module free_list #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_ARCH_REGS = 32,
  parameter int PW            = $clog2(NUM_PHYS_REGS)
) (
  input logic       clk,
  input logic       reset,
  free_list_if.slave bus
);
  localparam int FREE_INIT = NUM_PHYS_REGS - NUM_ARCH_REGS;
  // Two extra slots absorb frees already in flight when the list is nominally full.
  localparam int CAP       = FREE_INIT + 2;

  logic [PW-1:0] fl [NUM_PHYS_REGS];
  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  logic          overflow;

  logic [1:0]    n_req;
  logic [1:0]    granted_n;
  logic          grant;
  logic          free_req;
  logic          at_cap;
  logic          push;
  logic [PW-1:0] head_nxt1;

  always_comb begin
    n_req         = {1'b0, bus.req_valid[0]} + {1'b0, bus.req_valid[1]};
    bus.int_stall = bus.recall_checkpoint || (count < (PW+1)'(n_req));
    grant         = !bus.ext_stall && !bus.int_stall && (n_req != 2'd0);
    granted_n     = grant ? n_req : 2'd0;
    free_req      = bus.free_valid && (bus.free_phys_reg != '0);
    at_cap        = (count == (PW+1)'(CAP));
    push          = free_req && !at_cap;
    head_nxt1     = head + 1'b1;
  end

  for (genvar i = 0; i < 2; i++) begin : g_lane
    free_list_lane #(.PW(PW), .LANE(i)) u_lane (
      .grant     (grant),
      .req_valid (bus.req_valid),
      .head_ent  (fl[head]),
      .next_ent  (fl[head_nxt1]),
      .valid     (bus.alloc_valid[i]),
      .phys_rd   (bus.alloc_phys_rd[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PHYS_REGS; i++)
        fl[i] <= (i < FREE_INIT) ? PW'(NUM_ARCH_REGS + i) : '0;
      head     <= '0;
      tail     <= PW'(FREE_INIT);
      count    <= (PW+1)'(FREE_INIT);
      overflow <= 1'b0;
    end else begin
      if (push) begin
        fl[tail] <= bus.free_phys_reg;
        tail     <= tail + 1'b1;
      end
      if (free_req && at_cap) overflow <= 1'b1;
      if (bus.recall_checkpoint) begin
        // Distance from restored head to tail is the free population; it never aliases to full.
        head  <= bus.new_head;
        count <= {1'b0, PW'(tail - bus.new_head)} + (PW+1)'(push);
      end else begin
        head  <= head + PW'(granted_n);
        count <= count + (PW+1)'(push) - (PW+1)'(granted_n);
      end
    end
  end

  assign bus.fl_head_ptr  = head;
  assign bus.free_count   = count;
  assign bus.overflow_err = overflow;
endmodule

// File: doc/free_list.md
# free_list

Physical-register free list for the rename stage. It hands out up to two free physical registers per cycle to the renaming instructions, and reclaims one physical register per cycle from active-list graduation. Its head pointer is exported for checkpointing and can be restored on branch recovery. It is the producer of `phys_rd` for allocation and the consumer of `free_phys_reg` / `free_phys_reg_valid`.

## Interface
- `NUM_PHYS_REGS`, default 64: physical register count and FIFO depth; must be a power of two.
- `NUM_ARCH_REGS`, default 32: architectural registers, mapped 1:1 to `p0..p31` at reset.
- `PW`, default `$clog2(NUM_PHYS_REGS)` (6): physical register index / pointer width.
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `ext_stall` in 1: downstream stall; suppresses allocation.
- `req_valid[2]` in 1 each: slot i needs a destination register (`valid_instr[i] && uses_rd[i]`).
- `alloc_phys_rd[2]` out `PW` each: granted register per slot; 0 when not granted.
- `alloc_valid[2]` out 1 each: slot i granted this cycle.
- `int_stall` out 1: insufficient free registers, or recovery in progress.
- `free_valid` in 1: graduation returns a register (from `free_phys_reg_valid`).
- `free_phys_reg` in `PW`: register being returned.
- `fl_head_ptr` out `PW`: current head; snapshotted by the checkpoint unit.
- `recall_checkpoint` in 1: restore the head pointer.
- `new_head` in `PW`: head value to restore.
- `free_count` out `PW+1`: registers currently free.
- `overflow_err` out 1: sticky; set when a push would exceed capacity.

## Operation
- Circular FIFO `fl[NUM_PHYS_REGS]` of `PW`-bit entries, plus `head` (next to allocate), `tail` (next write slot) and `count` (`PW+1` bits).
- Reset: `fl[i] = NUM_ARCH_REGS + i` for `i < NUM_PHYS_REGS-NUM_ARCH_REGS`. `head=0`, `tail=NUM_PHYS_REGS-NUM_ARCH_REGS` (32), `count=32`, `overflow_err=0`. All outputs are combinational from this state, so after reset `int_stall=0` with no requests, and `alloc_*=0`.
- `n_req = req_valid[0] + req_valid[1]`.
- `int_stall = recall_checkpoint || (count < n_req)`.
- `grant = !ext_stall && !int_stall && n_req != 0`.
- Grant with both slots requesting:
  - `alloc_phys_rd[0]=fl[head]`, `alloc_phys_rd[1]=fl[head+1]`.
  - Next `head = head+2`.
- Grant with one slot requesting (either slot): that slot gets `fl[head]` and next `head = head+1`. The other slot's outputs are 0.
- Pointer arithmetic is modulo `NUM_PHYS_REGS`, using natural `PW`-bit wrap.
- Free handling: when `free_valid && free_phys_reg != 0`, write `fl[tail] <= free_phys_reg` and advance `tail+1`. Frees of `p0` (x0) are dropped.
- A free is accepted every cycle, regardless of `ext_stall`, `int_stall` or recall.
- Count update, no recall: `count <= count + push - granted_n`.
- Recall:
  - `head <= new_head`; no allocation this cycle.
  - `count <= ((tail - new_head) mod NUM_PHYS_REGS) + push`.
  - A result of 0 means empty. Full/empty aliasing cannot occur, because at least `NUM_ARCH_REGS` registers are always mapped.
- Overflow: if `push` occurs while `count == NUM_PHYS_REGS - NUM_ARCH_REGS + 2`, set `overflow_err` and drop the push. The `+2` slack covers in-flight frees. `overflow_err` clears only on `reset`.

## Timing
- Allocation is zero-latency: grants and indices are valid combinationally in the request cycle. Pointers update at the next edge.
- A freed register is not bypassed: it becomes allocatable the cycle after `free_valid`.
- Simultaneous free and allocation in one cycle: both take effect, net `count` change is `1 - granted_n`.
- Recall and free in the same cycle: the free is kept, and the restored `count` includes it.
- `reset` overrides everything, including mid-recall and mid-allocation. State is as listed in Operation the following cycle.
- `fl_head_ptr` reflects the registered head. A checkpoint taken in a grant cycle stores the pre-allocation head.

## Test plan
- Reset, then dual request with no stall:
  - `alloc_phys_rd = {32, 33}`, `alloc_valid = {1, 1}`.
  - Next cycle `fl_head_ptr=2`, `free_count=30`.
- Drain to `count=1`, then dual request:
  - `int_stall=1`, `alloc_valid = {0, 0}`, `alloc_phys_rd = {0, 0}`.
  - Single request on slot 1 grants `fl[head]` on slot 1 only.
- At `count=0`, pulse `free_valid` with `free_phys_reg=5` alongside a single request:
  - Request stalls this cycle.
  - Next cycle the request is granted `alloc_phys_rd=5`.
- `free_valid` with `free_phys_reg=0`: no change to `tail` or `free_count`.
- Allocate 10 registers (head=10), then recall with `new_head=4` and a simultaneous free of `p40`:
  - `int_stall=1` during recall; no allocation that cycle.
  - Next cycle `fl_head_ptr=4`, `free_count=29`.
- Run 200 cycles of random alloc/free with `tail` wrapping past 63→0:
  - Allocated values match a reference FIFO model.
  - `overflow_err` stays 0.
  - A forced extra free at `count=34` sets `overflow_err=1`.
